commit_unit: RTL
================

# commit_unit

In-order retirement stage that consumes the reorder buffer's head-of-queue commit port and returns the pop handshake. It performs the architectural side effects of each retired entry:
- register-file writeback
- store release to the load/store buffer
- misprediction flush and fetch redirect

It sits between the ROB and the register file, LSB and IF stage, and it is the sole source of the global flush `rst_c`.

## Interface
Parameters:
- `XLEN`, default 32: data and PC width.
- `ROB_AW`, default 5: ROB index width (32 entries).

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `rdy`  input  1  global ready; 0 freezes the block.
- `commit_en_i`  input  1  ROB head entry valid and ready.
- `commit_id_i`  input  ROB_AW  ROB index of the head entry.
- `commit_regaddr_i`  input  5  destination register.
- `commit_data_i`  input  XLEN  result value.
- `commit_pc_i`  input  XLEN  resolved target PC.
- `commit_branch_tag_i`  input  2  entry class: 00 ALU/load, 01 branch, 10 jal/jalr, 11 store.
- `commit_cond_i`  input  1  1 = mispredicted (only meaningful for classes 01 and 10).
- `commit_rdy_o`  output  1  combinational pop pulse to the ROB.
- `rf_we_o`  output  1  register-file write enable.
- `rf_waddr_o`  output  5  register-file write address.
- `rf_wdata_o`  output  XLEN  register-file write data.
- `rf_wrob_o`  output  ROB_AW  retiring ROB id; the register file clears its rename tag only on a match.
- `st_en_o`  output  1  release-store pulse to the LSB.
- `st_rob_o`  output  ROB_AW  ROB id of the released store.
- `st_done_i`  input  1  the LSB has written memory for the released store.
- `rst_c_o`  output  1  flush pulse to the ROB, RS, LSB and IF.
- `redirect_en_o`  output  1  fetch redirect valid.
- `redirect_pc_o`  output  XLEN  fetch redirect target.
- `retire_cnt_o`  output  32  number of retired entries.
- `flush_cnt_o`  output  16  number of flushes.

## Operation
- The FSM has three states: IDLE, STORE_WAIT and FLUSH. Reset state is IDLE.
- **Accept.** An entry is accepted in an edge cycle where `commit_rdy_o`=1.
  - `commit_rdy_o` = `rdy` & ((IDLE & `commit_en_i` & tag≠11) | (STORE_WAIT & `st_done_i`)).
  - It is a pure function of state and inputs and has no register.
- **IDLE with class 00**, on accept:
  - Register `rf_we_o`=(regaddr≠0) for the next cycle, with `rf_waddr_o`, `rf_wdata_o` and `rf_wrob_o` taken from the entry.
  - Writes to x0 are suppressed.
- **IDLE with class 01**, on accept:
  - cond=0: retire only.
  - cond=1: go to FLUSH.
- **IDLE with class 10**, on accept:
  - Perform the register write exactly as for class 00.
  - If cond=1, also go to FLUSH.
- **IDLE with class 11** (store):
  - `commit_rdy_o` stays 0.
  - Register `st_en_o`=1 and `st_rob_o`=id for one cycle, then go to STORE_WAIT.
- **STORE_WAIT:**
  - Hold until `st_done_i`=1. In that cycle `commit_rdy_o`=1, and the next state is IDLE.
  - The store writes no register.
- **Entering FLUSH** (registered on the accept edge): `rst_c_o`=1, `redirect_en_o`=1, `redirect_pc_o`=`commit_pc_i`, `flush_cnt_o`+1.
- **FLUSH:**
  - Lasts exactly one cycle, then returns to IDLE.
  - `commit_en_i` is ignored here because the ROB output is stale.
- **Counters:**
  - `retire_cnt_o` increments by 1 on every accept.
  - Both counters wrap modulo 2^width.
- **Pulses:** `rf_we_o`, `st_en_o`, `rst_c_o` and `redirect_en_o` are 1-cycle pulses that default to 0.
- **`rdy`=0:**
  - All registers hold, including the pulse outputs and the state.
  - `commit_rdy_o`=0 and no accept happens.

## Timing
- **Reset values:** every output register is 0, state is IDLE, and both counters are 0. `commit_rdy_o` is 0 while `rst`=0.
- **Reset mid-operation:** assertion aborts STORE_WAIT and FLUSH immediately.
- **Accept-to-effect latency:** 1 cycle to `rf_we_o`, `rst_c_o` and `redirect_en_o`.
- **Throughput:** one non-store entry per cycle when `commit_en_i` is held high. The ROB re-presents the next head on the cycle after the pop.
- **Store path:**
  - `st_en_o` is high 1 cycle after the head is presented.
  - `st_done_i` is honoured no earlier than the cycle after `st_en_o`. The earliest pop is 2 cycles after presentation.
  - If `st_done_i` is high while in IDLE, it is ignored.
- **Flush and writeback together:** a mispredicted class 10 produces `rf_we_o` and `rst_c_o` in the same cycle. The register write must take effect, because it belongs to the older, correct-path entry.
- **After flush:** the first accept is possible at the earliest in the cycle after FLUSH.

## Test plan
- **Back-to-back ALU commits.** Stimulus: three class-00 entries, ids 3/4/5, regs x5/x6/x0, data 0x11/0x22/0x33, `commit_en_i` held high. Response:
  - `commit_rdy_o` is high 3 consecutive cycles.
  - Writes (5,0x11,3) and (6,0x22,4) occur; there is no write for x0.
  - `retire_cnt_o`=3.
- **Store handshake.** Stimulus: class-11 id 7, with `st_done_i` asserted 4 cycles after `st_en_o`. Response:
  - `st_en_o` is a single pulse with `st_rob_o`=7.
  - `commit_rdy_o` goes high only in the `st_done_i` cycle.
  - No `rf_we_o` is produced.
- **Branch mispredict.** Stimulus: class-01 cond=1 pc=0x0000_1040, followed by a valid stale entry. Response:
  - Next cycle: `rst_c_o`=1 and `redirect_pc_o`=0x1040.
  - The stale entry is not accepted.
  - `flush_cnt_o`=1.
- **Jalr mispredict.** Stimulus: class-10 cond=1 rd=x1 data=0x104 pc=0x2000. Response: in the same cycle, `rf_we_o` writes x1=0x104 and `rst_c_o`/`redirect_pc_o`=0x2000.
- **Freeze.** Stimulus: `rdy`=0 for 3 cycles while a class-00 entry is presented. Response: `commit_rdy_o`=0 and outputs are frozen; the accept happens on the first cycle with `rdy`=1.
- **Asynchronous reset in STORE_WAIT.** Stimulus: drop `rst` in the middle of a cycle while in STORE_WAIT. Response:
  - All outputs are 0 immediately.
  - After release, the block is IDLE and a subsequent `st_done_i` is ignored.

Source files
------------

// File: rtl/commit_unit_if.sv
// Commit port between the reorder buffer head and the commit unit.
// The ROB drives the head entry; the commit unit answers with the pop pulse.
interface commit_unit_if #(
    parameter int XLEN   = 32,
    parameter int ROB_AW = 5
);
    logic              commit_en_i;
    logic [ROB_AW-1:0] commit_id_i;
    logic [4:0]        commit_regaddr_i;
    logic [XLEN-1:0]   commit_data_i;
    logic [XLEN-1:0]   commit_pc_i;
    logic [1:0]        commit_branch_tag_i;
    logic              commit_cond_i;
    logic              commit_rdy_o;

    modport master (
        output commit_en_i, commit_id_i, commit_regaddr_i, commit_data_i,
               commit_pc_i, commit_branch_tag_i, commit_cond_i,
        input  commit_rdy_o
    );

    modport slave (
        input  commit_en_i, commit_id_i, commit_regaddr_i, commit_data_i,
               commit_pc_i, commit_branch_tag_i, commit_cond_i,
        output commit_rdy_o
    );
endinterface

// File: rtl/commit_unit.sv
// In-order retirement stage: register writeback, store release to the LSB,
// misprediction flush and fetch redirect. Sole source of the global flush.
module commit_unit #(
    parameter int XLEN   = 32,
    parameter int ROB_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    commit_unit_if.slave      rob,
    output logic              rf_we_o,
    output logic [4:0]        rf_waddr_o,
    output logic [XLEN-1:0]   rf_wdata_o,
    output logic [ROB_AW-1:0] rf_wrob_o,
    output logic              st_en_o,
    output logic [ROB_AW-1:0] st_rob_o,
    input  logic              st_done_i,
    output logic              rst_c_o,
    output logic              redirect_en_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic [31:0]       retire_cnt_o,
    output logic [15:0]       flush_cnt_o
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] STORE_WAIT = 2'd1;
    localparam logic [1:0] FLUSH      = 2'd2;

    localparam logic [1:0] TAG_ALU   = 2'b00;
    localparam logic [1:0] TAG_JUMP  = 2'b10;
    localparam logic [1:0] TAG_STORE = 2'b11;

    logic [1:0]        state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic [ROB_AW-1:0] rf_wrob_q, rf_wrob_d;
    logic              st_en_q, st_en_d;
    logic [ROB_AW-1:0] st_rob_q, st_rob_d;
    logic              rst_c_q, rst_c_d;
    logic              redirect_en_q, redirect_en_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic [31:0]       retire_cnt_q, retire_cnt_d;
    logic [15:0]       flush_cnt_q, flush_cnt_d;

    logic accept_idle;
    logic accept_store;
    logic accept;

    // Pop decision. While st_en_o is still high the LSB cannot have written
    // memory yet, so st_done_i is only honoured from the following cycle.
    always_comb begin
        accept_idle  = (state_q == IDLE) && rob.commit_en_i
                       && (rob.commit_branch_tag_i != TAG_STORE);
        accept_store = (state_q == STORE_WAIT) && st_done_i && !st_en_q;
        accept       = rst && rdy && (accept_idle || accept_store);
    end

    assign rob.commit_rdy_o = accept;

    // Next-state and output-register computation; everything holds when rdy=0.
    always_comb begin
        state_d       = state_q;
        rf_we_d       = rf_we_q;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        rf_wrob_d     = rf_wrob_q;
        st_en_d       = st_en_q;
        st_rob_d      = st_rob_q;
        rst_c_d       = rst_c_q;
        redirect_en_d = redirect_en_q;
        redirect_pc_d = redirect_pc_q;
        retire_cnt_d  = retire_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        if (rdy) begin
            rf_we_d       = 1'b0;
            st_en_d       = 1'b0;
            rst_c_d       = 1'b0;
            redirect_en_d = 1'b0;
            if (accept) begin
                retire_cnt_d = retire_cnt_q + 32'd1;
            end
            case (state_q)
                IDLE: begin
                    if (rob.commit_en_i && rob.commit_branch_tag_i == TAG_STORE) begin
                        st_en_d  = 1'b1;
                        st_rob_d = rob.commit_id_i;
                        state_d  = STORE_WAIT;
                    end else if (accept_idle) begin
                        if (rob.commit_branch_tag_i == TAG_ALU ||
                            rob.commit_branch_tag_i == TAG_JUMP) begin
                            rf_we_d    = (rob.commit_regaddr_i != 5'd0);
                            rf_waddr_d = rob.commit_regaddr_i;
                            rf_wdata_d = rob.commit_data_i;
                            rf_wrob_d  = rob.commit_id_i;
                        end
                        if (rob.commit_branch_tag_i != TAG_ALU && rob.commit_cond_i) begin
                            rst_c_d       = 1'b1;
                            redirect_en_d = 1'b1;
                            redirect_pc_d = rob.commit_pc_i;
                            flush_cnt_d   = flush_cnt_q + 16'd1;
                            state_d       = FLUSH;
                        end
                    end
                end
                STORE_WAIT: begin
                    if (accept_store) begin
                        state_d = IDLE;
                    end
                end
                FLUSH:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            rf_wrob_q     <= '0;
            st_en_q       <= 1'b0;
            st_rob_q      <= '0;
            rst_c_q       <= 1'b0;
            redirect_en_q <= 1'b0;
            redirect_pc_q <= '0;
            retire_cnt_q  <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            rf_wrob_q     <= rf_wrob_d;
            st_en_q       <= st_en_d;
            st_rob_q      <= st_rob_d;
            rst_c_q       <= rst_c_d;
            redirect_en_q <= redirect_en_d;
            redirect_pc_q <= redirect_pc_d;
            retire_cnt_q  <= retire_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign rf_we_o       = rf_we_q;
    assign rf_waddr_o    = rf_waddr_q;
    assign rf_wdata_o    = rf_wdata_q;
    assign rf_wrob_o     = rf_wrob_q;
    assign st_en_o       = st_en_q;
    assign st_rob_o      = st_rob_q;
    assign rst_c_o       = rst_c_q;
    assign redirect_en_o = redirect_en_q;
    assign redirect_pc_o = redirect_pc_q;
    assign retire_cnt_o  = retire_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
endmodule
